// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
//   Shared definitions for the synchronous up/down modulus counter.
//   - DIR_DOWN / DIR_UP : encodings of the up_dn input.
//   - sel_e             : next-state selector used by counter_next_state.
//   - CALC_W            : widest internal arithmetic width (16-bit counter + 1).
//   - clamp_to_max()    : limits a value to a supplied maximum (MODULUS-1).
//   Optional build macro SYNC_UPDOWN_COUNTER_SATURATE_EN is consumed by
//   counter_next_state; nothing in this package depends on it.
// ----------------------------------------------------------------------------
package counter_pkg;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Largest supported WIDTH is 16, so WIDTH+1 arithmetic never exceeds 17 bits.
    localparam int CALC_W = 17;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_INC  = 2'd2,
        SEL_DEC  = 2'd3
    } sel_e;

    // Returns value unless it exceeds max_value, in which case max_value.
    function automatic logic [CALC_W-1:0] clamp_to_max(
        input logic [CALC_W-1:0] value,
        input logic [CALC_W-1:0] max_value
    );
        logic [CALC_W-1:0] result;
        if (value > max_value) begin
            result = max_value;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage : counter_pkg

// File: rtl/counter_next_state.sv
// ----------------------------------------------------------------------------
// counter_next_state
//   Purely combinational next-state logic for sync_updown_counter.
//   Priority: load > en (step in up_dn direction) > hold.
//   Parameters:
//     WIDTH   : counter width in bits (1..16)
//     MODULUS : count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//   Ports:
//     count      in  WIDTH  current registered count
//     up_dn      in  1      direction, 1 = up, 0 = down
//     en         in  1      step enable
//     load       in  1      parallel load request
//     load_val   in  WIDTH  value to load (clamped to MODULUS-1)
//     next_count out WIDTH  count for the next edge
//     wrap_next  out 1      next value of the registered wrap pulse
//     tc         out 1      terminal count for the current direction
//   Build option: SYNC_UPDOWN_COUNTER_SATURATE_EN makes stepping past either
//   end hold at that end instead of wrapping; wrap_next is then always 0.
// ----------------------------------------------------------------------------
module counter_next_state
    import counter_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_dn,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap_next,
    output logic             tc
);

    // Arithmetic is done one bit wider than the counter so that +1 at the
    // top of a non-power-of-two range is compared against MODULUS-1 before
    // any truncation, and never relies on natural WIDTH overflow.
    localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ZERO_W = {(WIDTH+1){1'b0}};
    localparam logic [WIDTH:0] ONE_W  = {{WIDTH{1'b0}}, 1'b1};

    if ((WIDTH < 1) || (WIDTH > 16) || (MODULUS < 2) ||
        (MODULUS > (1 << WIDTH))) begin : g_bad_params
        $error("counter_next_state: unsupported WIDTH/MODULUS combination");
    end

    sel_e           sel_s;
    logic [WIDTH:0] count_ext_s;
    logic [WIDTH:0] next_ext_s;
    logic           at_max_s;
    logic           at_zero_s;

    // Terminal-value detection on the zero-extended count.
    always_comb begin
        count_ext_s = {1'b0, count};
        at_max_s    = (count_ext_s == MAX_W);
        at_zero_s   = (count_ext_s == ZERO_W);
    end

    // Select the operation for this edge: load beats stepping beats holding.
    always_comb begin
        sel_s = SEL_HOLD;
        if (load) begin
            sel_s = SEL_LOAD;
        end else if (en) begin
            if (up_dn == DIR_UP) begin
                sel_s = SEL_INC;
            end else begin
                sel_s = SEL_DEC;
            end
        end else begin
            sel_s = SEL_HOLD;
        end
    end

    // Next count and wrap pulse for the selected operation.
    always_comb begin
        next_ext_s = count_ext_s;
        wrap_next  = 1'b0;
        case (sel_s)
            SEL_LOAD: begin
                next_ext_s = (WIDTH+1)'(clamp_to_max(CALC_W'(load_val),
                                                     CALC_W'(MODULUS - 1)));
                wrap_next  = 1'b0;
            end
            SEL_INC: begin
                if (at_max_s) begin
`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
                    next_ext_s = MAX_W;
                    wrap_next  = 1'b0;
`else
                    next_ext_s = ZERO_W;
                    wrap_next  = 1'b1;
`endif
                end else begin
                    next_ext_s = count_ext_s + ONE_W;
                    wrap_next  = 1'b0;
                end
            end
            SEL_DEC: begin
                if (at_zero_s) begin
`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
                    next_ext_s = ZERO_W;
                    wrap_next  = 1'b0;
`else
                    next_ext_s = MAX_W;
                    wrap_next  = 1'b1;
`endif
                end else begin
                    next_ext_s = count_ext_s - ONE_W;
                    wrap_next  = 1'b0;
                end
            end
            SEL_HOLD: begin
                next_ext_s = count_ext_s;
                wrap_next  = 1'b0;
            end
            default: begin
                next_ext_s = count_ext_s;
                wrap_next  = 1'b0;
            end
        endcase
    end

    // Truncate only after the modulus decision has been made.
    always_comb begin
        next_count = next_ext_s[WIDTH-1:0];
    end

    // Terminal count: a step is pending and the count sits at the end it
    // will leave from; load suppresses it because no step occurs.
    always_comb begin
        tc = 1'b0;
        if (en && !load) begin
            if (up_dn == DIR_UP) begin
                tc = at_max_s;
            end else begin
                tc = at_zero_s;
            end
        end else begin
            tc = 1'b0;
        end
    end

endmodule : counter_next_state

// File: rtl/sync_updown_counter.sv
// ----------------------------------------------------------------------------
// sync_updown_counter
//   Synchronous parameterised modulus up/down counter with parallel load,
//   combinational terminal count and a registered one-cycle wrap pulse.
//   This level holds only the state registers and the reset; all next-state
//   decisions live in counter_next_state.
//   Parameters:
//     WIDTH   : counter / LED bus width (1..16), default 3
//     MODULUS : count range 0..MODULUS-1, default 8
//   Ports:
//     clk      in  1      rising-edge clock
//     rst      in  1      asynchronous active-high reset
//     en       in  1      count enable
//     up_dn    in  1      direction, 1 = up, 0 = down
//     load     in  1      synchronous parallel load
//     load_val in  WIDTH  load value (clamped to MODULUS-1)
//     count    out WIDTH  registered count
//     leds     out WIDTH  registered LED drive, always equal to count
//     tc       out 1      combinational terminal count
//     wrap     out 1      registered pulse in the cycle after a wrap step
//   Build option: define SYNC_UPDOWN_COUNTER_SATURATE_EN to saturate at the
//   ends of the range instead of wrapping (wrap then stays 0).
// ----------------------------------------------------------------------------
module sync_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] leds,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] leds_q;
    logic [WIDTH-1:0] leds_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [WIDTH-1:0] next_count_s;
    logic             wrap_next_s;
    logic             tc_s;

    counter_next_state #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next_state (
        .count      (count_q),
        .up_dn      (up_dn),
        .en         (en),
        .load       (load),
        .load_val   (load_val),
        .next_count (next_count_s),
        .wrap_next  (wrap_next_s),
        .tc         (tc_s)
    );

    // Register inputs; leds is a separate flop so it can drive pads
    // independently while always holding the same value as count.
    always_comb begin
        count_d = next_count_s;
        leds_d  = next_count_s;
        wrap_d  = wrap_next_s;
    end

    // State registers with asynchronous reset; reset discards any pending step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {WIDTH{1'b0}};
            leds_q  <= {WIDTH{1'b0}};
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            leds_q  <= leds_d;
            wrap_q  <= wrap_d;
        end
    end

    // Drive outputs.
    always_comb begin
        count = count_q;
        leds  = leds_q;
        wrap  = wrap_q;
        tc    = tc_s;
    end

endmodule : sync_updown_counter

// File: tb/tb_sync_updown_counter.sv
// ----------------------------------------------------------------------------
// tb_sync_updown_counter
//   Self-checking bench for sync_updown_counter with WIDTH=3, MODULUS=6.
//   A plain-arithmetic model (modulo / min) predicts count, leds, wrap and tc;
//   directed sequences with literal expectations pin the model, followed by
//   randomized stimulus with occasional asynchronous reset pulses.
// ----------------------------------------------------------------------------
module tb_sync_updown_counter;

    localparam int W = 3;
    localparam int M = 6;

    logic         clk;
    logic         clk_run;
    logic         rst;
    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic [W-1:0] leds;
    logic         tc;
    logic         wrap;

    int n_total;
    int n_pass;
    int m_count;
    int m_wrap;

    sync_updown_counter #(
        .WIDTH   (W),
        .MODULUS (M)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .leds     (leds),
        .tc       (tc),
        .wrap     (wrap)
    );

    // Gated clock so reset can be exercised with no edges at all.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_tc();
        if (en && !load) begin
            if (up_dn) return (m_count == M - 1) ? 1 : 0;
            else       return (m_count == 0) ? 1 : 0;
        end
        return 0;
    endfunction

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_step();
        if (load) begin
            m_count = (int'(load_val) > M - 1) ? M - 1 : int'(load_val);
            m_wrap  = 0;
        end else if (en) begin
`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
            if (up_dn) m_count = (m_count + 1 > M - 1) ? M - 1 : m_count + 1;
            else       m_count = (m_count - 1 < 0) ? 0 : m_count - 1;
            m_wrap = 0;
`else
            if (up_dn) begin
                m_wrap  = (m_count + 1 >= M) ? 1 : 0;
                m_count = (m_count + 1) % M;
            end else begin
                m_wrap  = (m_count == 0) ? 1 : 0;
                m_count = (m_count + M - 1) % M;
            end
`endif
        end else begin
            m_wrap = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_count"}, int'(count), m_count);
        check({tag, "_leds"},  int'(leds),  m_count);
        check({tag, "_wrap"},  int'(wrap),  m_wrap);
        check({tag, "_tc"},    int'(tc),    model_tc());
    endtask

    // One clock: check tc for freshly driven inputs, take the edge, check all.
    task automatic cycle();
        #1;
        check("tc_pre", int'(tc), model_tc());
        @(posedge clk);
        model_step();
        #1;
        compare_all("cyc");
    endtask

    // Reset asserted between edges must clear state immediately.
    task automatic pulse_reset();
        #1;
        rst     = 1'b1;
        m_count = 0;
        m_wrap  = 0;
        #1;
        compare_all("rst");
        #1;
        rst = 1'b0;
    endtask

    int exp_up [7];
    int exp_dn [3];

    initial begin
        n_total  = 0;
        n_pass   = 0;
        clk_run  = 1'b0;
        rst      = 1'b0;
        en       = 1'b0;
        up_dn    = 1'b1;
        load     = 1'b0;
        load_val = 3'd0;
        m_count  = 0;
        m_wrap   = 0;

        // Reset with the clock stopped.
        #2;
        rst = 1'b1;
        #1;
        check("rst_nclk_count", int'(count), 0);
        check("rst_nclk_leds",  int'(leds),  0);
        check("rst_nclk_wrap",  int'(wrap),  0);
        check("rst_nclk_tc",    int'(tc),    0);
        #1;
        rst     = 1'b0;
        clk_run = 1'b1;
        @(negedge clk);

        // Count up from 0 for seven edges.
`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
        exp_up = '{1, 2, 3, 4, 5, 5, 5};
`else
        exp_up = '{1, 2, 3, 4, 5, 0, 1};
`endif
        en    = 1'b1;
        up_dn = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cycle();
            check("up_seq_count", int'(count), exp_up[i]);
`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
            check("up_seq_wrap", int'(wrap), 0);
`else
            check("up_seq_wrap", int'(wrap), (i == 5) ? 1 : 0);
`endif
            if (i == 4) check("up_tc_at_5", int'(tc), 1);
        end

        // Return to 0 by load, then count down.
        load     = 1'b1;
        en       = 1'b0;
        load_val = 3'd0;
        cycle();
        check("load0_count", int'(count), 0);
        load  = 1'b0;
        en    = 1'b1;
        up_dn = 1'b0;
        #1;
        check("dn_tc_first", int'(tc), 1);
`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
        exp_dn = '{0, 0, 0};
`else
        exp_dn = '{5, 4, 3};
`endif
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("dn_seq_count", int'(count), exp_dn[i]);
`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
            check("dn_seq_wrap", int'(wrap), 0);
`else
            check("dn_seq_wrap", int'(wrap), (i == 0) ? 1 : 0);
`endif
        end

        // Load with en high: clamp, no step.
        load     = 1'b1;
        en       = 1'b1;
        up_dn    = 1'b1;
        load_val = 3'd7;
        cycle();
        check("load_clamp_count", int'(count), 5);
        check("load_clamp_wrap",  int'(wrap),  0);
        check("load_clamp_tc",    int'(tc),    0);
        load_val = 3'd2;
        cycle();
        check("load2_count", int'(count), 2);

        // Direction change takes effect on the same edge.
        load_val = 3'd3;
        cycle();
        check("load3_count", int'(count), 3);
        load  = 1'b0;
        up_dn = 1'b0;
        cycle();
        check("flip_dn_count", int'(count), 2);
        up_dn = 1'b1;
        cycle();
        check("flip_up_count", int'(count), 3);
        cycle();
        check("pre_rst_count", int'(count), 4);
        #1;
        rst     = 1'b1;
        m_count = 0;
        m_wrap  = 0;
        #1;
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_leds",  int'(leds),  0);
        #1;
        rst = 1'b0;

`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
        // Saturation at the top from 4.
        load     = 1'b1;
        load_val = 3'd4;
        cycle();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("sat_up_count", int'(count), 5);
            check("sat_up_wrap",  int'(wrap),  0);
        end
`endif

        // Randomized stimulus against the model.
        for (int i = 0; i < 600; i++) begin
            load     = ($urandom_range(0, 7) == 0);
            en       = ($urandom_range(0, 3) != 0);
            up_dn    = 1'($urandom_range(0, 1));
            load_val = 3'($urandom_range(0, 7));
            cycle();
            if ($urandom_range(0, 49) == 0) pulse_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_sync_updown_counter
